// File: rtl/srl64_fifo_ctl_pkg.sv
// Shared constants for the SRL-backed byte FIFO controller and its shift-register datapath.
//   SRL_DEPTH : number of SRL stages (entries held outside the output register)
//   DATA_W    : byte width
//   LVL_W     : width of occupancy counters (covers 0..65)
//   ADDR_W    : SRL tap address width
package srl64_fifo_ctl_pkg;

   localparam int unsigned SRL_DEPTH = 64;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned LVL_W     = 7;
   localparam int unsigned ADDR_W    = 6;

endpackage

// File: rtl/srl64x8e.sv
// 64-deep, 8-bit addressable shift register with clock enable.
// Ports:
//   i_clk : clock
//   i_ce  : shift enable; i_d enters stage 0 and every stage moves up one
//   i_d   : shift-in data
//   i_a   : tap address (0 = newest)
//   o_y   : combinational read of stage i_a (pre-edge contents)
// Contents are deliberately not reset.
module srl64x8e
   import srl64_fifo_ctl_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_ce,
   input  logic [DATA_W-1:0] i_d,
   input  logic [ADDR_W-1:0] i_a,
   output logic [DATA_W-1:0] o_y
);

   logic [DATA_W-1:0] r_sr [SRL_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_ce) begin
         r_sr[0] <= i_d;
         for (int i = 1; i < SRL_DEPTH; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
      end
   end

   assign o_y = r_sr[i_a];

endmodule

// File: rtl/srl64_fifo_ctl.sv
// Runs one srl64x8e as a 64-entry byte FIFO with a registered output stage (65 bytes total).
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_flush             : synchronous clear of occupancy (wins over write and load)
//   i_in_data/i_in_valid/o_in_ready    : write side handshake
//   o_out_data/o_out_valid/i_out_ready : read side handshake, o_out_data is registered
//   o_level             : occupancy, SRL count plus output stage
//   o_almost_full/o_almost_empty : registered thresholds on the next-state level
module srl64_fifo_ctl
   import srl64_fifo_ctl_pkg::*;
#(
   parameter int unsigned AFULL  = 48,
   parameter int unsigned AEMPTY = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [LVL_W-1:0]  o_level,
   output logic              o_almost_full,
   output logic              o_almost_empty
);

   localparam logic [LVL_W-1:0] FULL_CNT = LVL_W'(SRL_DEPTH);
   localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL);
   localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY);

   logic [LVL_W-1:0]  r_count, w_count_d;
   logic              r_out_valid, w_out_valid_d;
   logic [DATA_W-1:0] r_out_data, w_out_data_d;
   logic              r_afull, r_aempty;
   logic [LVL_W-1:0]  w_level_d;
   logic              w_wr, w_ld;
   logic [ADDR_W-1:0] w_srl_a;
   logic [DATA_W-1:0] w_srl_y;

   // in_ready depends combinationally only on flush, never on out_ready.
   assign o_in_ready = (r_count != FULL_CNT) & ~i_flush;
   assign w_wr       = i_in_valid & o_in_ready;
   assign w_ld       = (r_count != '0) & (~r_out_valid | i_out_ready);

   // Oldest entry sits at stage count-1.
   assign w_srl_a = (r_count != '0) ? ADDR_W'(r_count - LVL_W'(1)) : '0;

   srl64x8e u_srl (
      .i_clk (i_clk),
      .i_ce  (w_wr),
      .i_d   (i_in_data),
      .i_a   (w_srl_a),
      .o_y   (w_srl_y)
   );

   always_comb begin
      w_count_d     = r_count;
      w_out_valid_d = r_out_valid;
      w_out_data_d  = r_out_data;
      if (i_flush) begin
         w_count_d     = '0;
         w_out_valid_d = 1'b0;
      end else begin
         w_count_d = r_count + LVL_W'(w_wr) - LVL_W'(w_ld);
         if (w_ld) begin
            w_out_valid_d = 1'b1;
            w_out_data_d  = w_srl_y;
         end else if (r_out_valid & i_out_ready) begin
            w_out_valid_d = 1'b0;
         end
      end
      w_level_d = w_count_d + LVL_W'(w_out_valid_d);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
      end else begin
         r_count     <= w_count_d;
         r_out_valid <= w_out_valid_d;
         r_out_data  <= w_out_data_d;
         r_afull     <= (w_level_d >= AFULL_L);
         r_aempty    <= (w_level_d <= AEMPTY_L);
      end
   end

   assign o_out_valid    = r_out_valid;
   assign o_out_data     = r_out_data;
   assign o_level        = r_count + LVL_W'(r_out_valid);
   assign o_almost_full  = r_afull;
   assign o_almost_empty = r_aempty;

endmodule

// File: tb/tb_srl64_fifo_ctl.sv
// Bench for srl64_fifo_ctl: queue-level reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_srl64_fifo_ctl;

   localparam int AFULL  = 48;
   localparam int AEMPTY = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [6:0] level;
   logic       almost_full;
   logic       almost_empty;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   srl64_fifo_ctl #(
      .AFULL  (AFULL),
      .AEMPTY (AEMPTY)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_flush        (flush),
      .i_in_data      (in_data),
      .i_in_valid     (in_valid),
      .o_in_ready     (in_ready),
      .o_out_data     (out_data),
      .o_out_valid    (out_valid),
      .i_out_ready    (out_ready),
      .o_level        (level),
      .o_almost_full  (almost_full),
      .o_almost_empty (almost_empty)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Reference model: bytes waiting in the buffer plus one output holding slot.
   logic [7:0] m_q[$];
   bit         m_ov = 0;
   logic [7:0] m_od = 8'h00;
   bit         m_wr, m_ld;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_ov = 0;
         m_od = 8'h00;
      end else begin
         m_wr = in_valid && (m_q.size() < 64) && !flush;
         m_ld = (m_q.size() > 0) && (!m_ov || out_ready);
         if (flush) begin
            m_q.delete();
            m_ov = 0;
         end else begin
            if (m_ld) begin
               m_od = m_q.pop_front();
               m_ov = 1;
            end else if (m_ov && out_ready) begin
               m_ov = 0;
            end
            if (m_wr) m_q.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         int lvl;
         lvl = m_q.size() + int'(m_ov);
         check("model_in_ready", int'(in_ready), int'((m_q.size() != 64) && !flush));
         check("model_out_valid", int'(out_valid), int'(m_ov));
         if (m_ov) check("model_out_data", int'(out_data), int'(m_od));
         check("model_level", int'(level), lvl);
         check("model_almost_full", int'(almost_full), int'(lvl >= AFULL));
         check("model_almost_empty", int'(almost_empty), int'(lvl <= AEMPTY));
      end
   end

   // Inputs change 2 time units after a rising edge and are held across the next edge.
   task automatic step(input bit v, input logic [7:0] d, input bit r, input bit f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      check("rst_level", int'(level), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_almost_empty", int'(almost_empty), 1);
      check("rst_almost_full", int'(almost_full), 0);
      step(0, 8'h00, 0, 0);

      // Single write: visible on the output two edges after it is accepted.
      step(1, 8'hA5, 0, 0);
      check("single_not_yet_valid", int'(out_valid), 0);
      check("single_level_k", int'(level), 1);
      step(0, 8'h00, 0, 0);
      check("single_out_valid", int'(out_valid), 1);
      check("single_out_data", int'(out_data), 8'hA5);
      check("single_level", int'(level), 1);
      check("single_almost_empty", int'(almost_empty), 1);
      step(0, 8'h00, 1, 0);
      check("single_drained", int'(level), 0);

      // Fill all 65 slots.
      for (int i = 0; i < 65; i++) step(1, 8'(i), 0, 0);
      check("full_level", int'(level), 65);
      check("full_in_ready", int'(in_ready), 0);
      check("full_almost_full", int'(almost_full), 1);
      step(1, 8'hFF, 0, 0);
      check("full_ignored_level", int'(level), 65);

      // Drain in order, one byte per cycle.
      for (int i = 0; i < 65; i++) begin
         check("drain_valid", int'(out_valid), 1);
         check("drain_data", int'(out_data), i);
         step(0, 8'h00, 1, 0);
      end
      check("drain_level", int'(level), 0);
      check("drain_out_valid", int'(out_valid), 0);

      // Streaming: after the 2-cycle latency, one byte per cycle with no gaps.
      for (int i = 0; i < 24; i++) begin
         step(1, 8'(8'h80 + i), 1, 0);
         if (i >= 1) begin
            check("stream_valid", int'(out_valid), 1);
            check("stream_data", int'(out_data), 8'h80 + i - 1);
            check("stream_level", int'(level), 2);
         end
      end
      repeat (3) step(0, 8'h00, 1, 0);
      check("stream_empty", int'(level), 0);

      // Flush at level 20 discards the concurrent write.
      for (int i = 0; i < 20; i++) step(1, 8'(8'h10 + i), 0, 0);
      check("pre_flush_level", int'(level), 20);
      step(1, 8'h99, 0, 1);
      check("flush_level", int'(level), 0);
      check("flush_out_valid", int'(out_valid), 0);
      step(1, 8'h3C, 0, 0);
      check("post_flush_k", int'(out_valid), 0);
      step(0, 8'h00, 0, 0);
      check("post_flush_valid", int'(out_valid), 1);
      check("post_flush_data", int'(out_data), 8'h3C);
      check("post_flush_level", int'(level), 1);
      repeat (2) step(0, 8'h00, 1, 0);

      // Asynchronous reset between edges at level 30.
      for (int i = 0; i < 30; i++) step(1, 8'(8'h40 + i), 0, 0);
      check("pre_rst_level", int'(level), 30);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("arst_level", int'(level), 0);
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_in_ready", int'(in_ready), 1);
      check("arst_almost_empty", int'(almost_empty), 1);
      #2 rst = 1'b0;
      step(0, 8'h00, 0, 0);
      check("after_rst_in_ready", int'(in_ready), 1);
      check("after_rst_level", int'(level), 0);
      step(1, 8'h5A, 0, 0);
      step(0, 8'h00, 0, 0);
      check("after_rst_data", int'(out_data), 8'h5A);
      step(0, 8'h00, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
